// File: rtl/pico_bus_fabric.sv
// rtl/pico_bus_fabric.sv - picorv32 memory-bus fabric with slave regions, port bank and bus-error reporting
//
// Decodes cpu_addr[31:28] into up to NUM_SLAVES slave regions (region i at
// 4'hi) and an internal output-port bank at 4'hF. Each slave either gets a
// fabric-generated one-wait-state ready (FIXED_LAT_MASK bit set) or is
// waited on through s_ready with a TIMEOUT-cycle watchdog. Unmapped and
// timed-out accesses still complete, return zero and raise the sticky o_err.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   cpu_valid/addr/wdata/wstrb/ready/rdata   picorv32 native memory interface
//   s_sel             per-slave access qualifier (addr/wdata/wstrb come from the CPU bus)
//   s_ready           per-slave completion, handshake-mode slaves only
//   s_rdata           slave read data, slave i at [32i+31:32i]
//   o_port            output port registers, port k at [32k+31:32k]
//   o_err             sticky bus-error flag
module pico_bus_fabric #(
   parameter int                    NUM_SLAVES     = 4,
   parameter logic [NUM_SLAVES-1:0] FIXED_LAT_MASK = '1,
   parameter int                    NUM_PORTS      = 3,
   parameter int                    TIMEOUT        = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cpu_valid,
   input  logic [31:0]               cpu_addr,
   input  logic [31:0]               cpu_wdata,
   input  logic [3:0]                cpu_wstrb,
   output logic                      cpu_ready,
   output logic [31:0]               cpu_rdata,
   output logic [NUM_SLAVES-1:0]     s_sel,
   input  logic [NUM_SLAVES-1:0]     s_ready,
   input  logic [NUM_SLAVES*32-1:0]  s_rdata,
   output logic [NUM_PORTS*32-1:0]   o_port,
   output logic                      o_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [31:0] rdata_q;
   logic        fixed_q;
   logic [31:0] err_addr;
   logic [31:0] port_q [NUM_PORTS];

   logic [3:0]   r;
   logic [5:0]   w;
   logic         is_slave, is_port, is_fixed, sl_ready, timed_out;
   logic         err_set, err_clr, port_we;
   logic [31:0]  sl_rdata, port_rd;

   // Slave-side vectors widened to all 16 regions so a 4-bit region index
   // can select from them without running off the end.
   logic [15:0]  fixed_ext;
   logic [15:0]  ready_ext;
   logic [511:0] rdata_ext;

   assign r         = cpu_addr[31:28];
   assign w         = cpu_addr[7:2];
   assign fixed_ext = 16'(FIXED_LAT_MASK);
   assign ready_ext = 16'(s_ready);
   assign rdata_ext = 512'(s_rdata);

   assign is_slave  = {28'd0, r} < 32'(NUM_SLAVES);
   assign is_port   = (r == 4'hF);
   assign is_fixed  = is_slave & fixed_ext[r];
   assign sl_ready  = is_slave & ready_ext[r];
   assign sl_rdata  = rdata_ext[{r, 5'd0} +: 32];

   // Counter reads k-1 in the k-th cycle of the access (first WAIT cycle is 1),
   // so matching TIMEOUT-2 leaves WAIT in cycle TIMEOUT-1 and responds in TIMEOUT.
   assign timed_out = (cnt == 16'(TIMEOUT - 2));

   assign err_set = cpu_valid &
                    (((state == S_IDLE) & ~is_slave & ~is_port) |
                     ((state == S_WAIT) & ~sl_ready & timed_out));
   assign port_we = cpu_valid & (state == S_IDLE) & is_port;
   assign err_clr = port_we & (w == 6'd63) & cpu_wstrb[0] & cpu_wdata[0];

   always_comb begin
      port_rd = '0;
      for (int k = 0; k < NUM_PORTS; k++)
         if (w == 6'(k)) port_rd = port_q[k];
      if (w == 6'd62) port_rd = err_addr;
      if (w == 6'd63) port_rd = {31'd0, o_err};
   end

   always_comb begin
      s_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         s_sel[i] = cpu_valid & (r == 4'(i)) & (state != S_RESP) & ~rst;
   end

   assign cpu_ready = (state == S_RESP) & ~rst;
   // Fixed-latency slaves present their data in the response cycle itself.
   assign cpu_rdata = fixed_q ? sl_rdata : rdata_q;

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      assign o_port[32*k +: 32] = port_q[k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         rdata_q  <= '0;
         fixed_q  <= 1'b0;
         o_err    <= 1'b0;
         err_addr <= '0;
         for (int k = 0; k < NUM_PORTS; k++) port_q[k] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt     <= '0;
               fixed_q <= 1'b0;
               if (cpu_valid) begin
                  if (is_slave && !is_fixed) begin
                     if (sl_ready) begin
                        state   <= S_RESP;
                        rdata_q <= sl_rdata;
                     end else begin
                        state   <= S_WAIT;
                     end
                  end else begin
                     state   <= S_RESP;
                     fixed_q <= is_fixed;
                     rdata_q <= is_port ? port_rd : 32'd0;
                  end
               end
            end
            S_WAIT: begin
               if (!cpu_valid) begin
                  state <= S_IDLE;
               end else if (sl_ready) begin
                  state   <= S_RESP;
                  rdata_q <= sl_rdata;
               end else if (timed_out) begin
                  state   <= S_RESP;
                  rdata_q <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               state   <= S_IDLE;
               fixed_q <= 1'b0;
            end
         endcase

         // Set takes priority over a coincident clear.
         if (err_set) begin
            o_err    <= 1'b1;
            err_addr <= cpu_addr;
         end else if (err_clr) begin
            o_err    <= 1'b0;
         end

         for (int k = 0; k < NUM_PORTS; k++)
            if (port_we && w == 6'(k))
               for (int b = 0; b < 4; b++)
                  if (cpu_wstrb[b]) port_q[k][8*b +: 8] <= cpu_wdata[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_pico_bus_fabric.sv
// tb/tb_pico_bus_fabric.sv - directed self-checking bench for pico_bus_fabric
module tb_pico_bus_fabric;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_valid;
   logic [31:0]  cpu_addr, cpu_wdata;
   logic [3:0]   cpu_wstrb;
   logic         cpu_ready;
   logic [31:0]  cpu_rdata;
   logic [3:0]   s_sel;
   logic [3:0]   s_ready;
   logic [127:0] s_rdata;
   logic [95:0]  o_port;
   logic         o_err;

   int tests = 0;
   int fails = 0;

   pico_bus_fabric #(
      .NUM_SLAVES(4), .FIXED_LAT_MASK(4'b1101), .NUM_PORTS(3), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready),
      .cpu_rdata(cpu_rdata), .s_sel(s_sel), .s_ready(s_ready), .s_rdata(s_rdata),
      .o_port(o_port), .o_err(o_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle; inputs are driven right after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start an access in cycle 0; caller checks after settle.
   task automatic start(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      tick();
      cpu_valid = 1'b1;
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_wstrb = s;
      #1;
   endtask

   // Next cycle with valid still held (response cycle of picorv32).
   task automatic hold();
      tick();
      #1;
   endtask

   task automatic finish_access();
      tick();
      cpu_valid = 1'b0;
      cpu_wstrb = 4'd0;
      #1;
      chk("no_double_ready", cpu_ready, 1'b0);
   endtask

   initial begin
      rst = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
      s_ready = '0; s_rdata = '0;
      tick(); tick();
      #1;
      chk("rst_ready", cpu_ready, 1'b0);
      chk("rst_sel",   s_sel, 4'b0000);
      chk("rst_port",  o_port, 96'd0);
      chk("rst_err",   o_err, 1'b0);
      tick();
      rst = 1'b0;

      // Fixed-latency read from slave 0
      s_rdata[31:0] = 32'h1234_5678;
      start(32'h0000_0010, 32'd0, 4'd0);
      chk("fix_sel_c0",   s_sel, 4'b0001);
      chk("fix_ready_c0", cpu_ready, 1'b0);
      hold();
      chk("fix_ready_c1", cpu_ready, 1'b1);
      chk("fix_rdata",    cpu_rdata, 32'h1234_5678);
      chk("fix_sel_c1",   s_sel, 4'b0000);
      finish_access();

      // Port write with byte enables, then readback
      start(32'hF000_0004, 32'hAABB_CCDD, 4'b0101);
      chk("pw_sel", s_sel, 4'b0000);
      hold();
      chk("pw_ready", cpu_ready, 1'b1);
      chk("pw_port1", o_port[63:32], 32'h00BB_00DD);
      chk("pw_port0", o_port[31:0], 32'h0);
      finish_access();
      start(32'hF000_0004, 32'd0, 4'd0);
      hold();
      chk("pr_ready", cpu_ready, 1'b1);
      chk("pr_rdata", cpu_rdata, 32'h00BB_00DD);
      finish_access();

      // Handshake slave 1, s_ready in cycle 5
      start(32'h1000_0000, 32'd0, 4'd0);
      chk("hs_sel_c0", s_sel, 4'b0010);
      for (int c = 1; c <= 4; c++) begin
         hold();
         chk("hs_wait_ready", cpu_ready, 1'b0);
         chk("hs_wait_sel", s_sel, 4'b0010);
      end
      tick();
      s_ready[1] = 1'b1; s_rdata[63:32] = 32'hCAFE_F00D;
      #1;
      chk("hs_ready_c5", cpu_ready, 1'b0);
      tick();
      s_ready[1] = 1'b0; s_rdata[63:32] = 32'hDEAD_BEEF;
      #1;
      chk("hs_ready_c6", cpu_ready, 1'b1);
      chk("hs_rdata",    cpu_rdata, 32'hCAFE_F00D);
      chk("hs_err",      o_err, 1'b0);
      chk("hs_sel_c6",   s_sel, 4'b0000);
      finish_access();

      // Timeout on slave 1
      start(32'h1000_0040, 32'd0, 4'd0);
      for (int c = 1; c <= 7; c++) begin
         hold();
         chk("to_wait_ready", cpu_ready, 1'b0);
      end
      hold();
      chk("to_ready_c8", cpu_ready, 1'b1);
      chk("to_rdata",    cpu_rdata, 32'h0);
      chk("to_err",      o_err, 1'b1);
      finish_access();
      start(32'hF000_00F8, 32'd0, 4'd0);
      hold();
      chk("to_err_addr", cpu_rdata, 32'h1000_0040);
      finish_access();
      start(32'hF000_00FC, 32'd0, 4'd0);
      hold();
      chk("to_status", cpu_rdata, 32'h1);
      finish_access();
      start(32'hF000_00FC, 32'h1, 4'b0001);
      hold();
      chk("err_clear", o_err, 1'b0);
      finish_access();

      // s_ready in cycle TIMEOUT-1 wins over timeout
      start(32'h1000_0000, 32'd0, 4'd0);
      for (int c = 1; c <= 6; c++) hold();
      tick();
      s_ready[1] = 1'b1; s_rdata[63:32] = 32'h0BAD_CAFE;
      #1;
      chk("edge_ready_c7", cpu_ready, 1'b0);
      tick();
      s_ready[1] = 1'b0;
      #1;
      chk("edge_ready_c8", cpu_ready, 1'b1);
      chk("edge_rdata",    cpu_rdata, 32'h0BAD_CAFE);
      chk("edge_err",      o_err, 1'b0);
      finish_access();

      // Unmapped read
      start(32'h9000_0000, 32'd0, 4'd0);
      chk("um_sel", s_sel, 4'b0000);
      hold();
      chk("um_ready", cpu_ready, 1'b1);
      chk("um_rdata", cpu_rdata, 32'h0);
      chk("um_err",   o_err, 1'b1);
      finish_access();
      start(32'hF000_00F8, 32'd0, 4'd0);
      hold();
      chk("um_err_addr", cpu_rdata, 32'h9000_0000);
      finish_access();

      // Reset during WAIT cycle 3
      start(32'h1000_0000, 32'd0, 4'd0);
      hold(); hold();
      tick();
      rst = 1'b1;
      #1;
      chk("rw_sel",   s_sel, 4'b0000);
      chk("rw_ready", cpu_ready, 1'b0);
      tick();
      rst = 1'b0; cpu_valid = 1'b0;
      #1;
      chk("rw_ready_after", cpu_ready, 1'b0);
      chk("rw_port",        o_port, 96'd0);
      chk("rw_err",         o_err, 1'b0);
      s_rdata[31:0] = 32'h5555_AAAA;
      start(32'h0000_0000, 32'd0, 4'd0);
      chk("post_sel", s_sel, 4'b0001);
      hold();
      chk("post_ready", cpu_ready, 1'b1);
      chk("post_rdata", cpu_rdata, 32'h5555_AAAA);
      finish_access();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
